// File: rtl/tlul_boot_seq_pkg.sv
// Types for the boot-time TL-UL op sequencer: op table entries and FSM states.
package tlul_boot_seq_pkg;

  typedef enum logic {
    SeqWrite = 1'b0,
    SeqRead  = 1'b1
  } seq_kind_e;

  typedef struct packed {
    seq_kind_e   kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cmp_mask;
  } seq_op_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDelay = 3'd1,
    StReq   = 3'd2,
    StRsp   = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } boot_state_e;

  localparam int DelayW = 12;
  localparam int TimerW = 8;
  localparam int IdxW   = 4;

  // A read passes when every bit selected by cmp_mask matches the expected data.
  function automatic logic read_matches(input seq_op_t op, input logic [31:0] rdata);
    return ((rdata ^ op.data) & op.cmp_mask) == 32'h0;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL channel types shared by hosts and devices on the RoT crossbar.
// Only the fields exercised by single-beat 32-bit accesses are modelled.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    instr_type: 4'h9,
    cmd_intg:   7'h00,
    data_intg:  7'h00
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam tl_h2d_t TL_H2D_DEFAULT = '{
    a_valid:   1'b0,
    a_opcode:  PutFullData,
    a_param:   3'h0,
    a_size:    2'h0,
    a_source:  8'h00,
    a_address: 32'h0,
    a_mask:    4'h0,
    a_data:    32'h0,
    a_user:    TL_A_USER_DEFAULT,
    d_ready:   1'b1
  };

  localparam tl_d2h_t TL_D2H_DEFAULT = '{
    d_valid:  1'b0,
    d_opcode: AccessAck,
    d_param:  3'h0,
    d_size:   2'h0,
    d_source: 8'h00,
    d_sink:   1'b0,
    d_data:   32'h0,
    d_user:   14'h0,
    d_error:  1'b0,
    a_ready:  1'b1
  };

endpackage

// File: rtl/tlul_boot_seq.sv
// Boot sequencer: after a start delay, walks a fixed table of TL-UL writes/reads,
// checking read data and response errors, and stops in DONE or ERROR until reset.
//   state | meaning
//   IDLE  | waiting for start_i
//   DELAY | counting StartDelay cycles before the first request
//   REQ   | A channel valid for the current op, waiting for a_ready
//   RSP   | waiting for the D response, timeout counter running
//   DONE  | all ops completed cleanly
//   ERROR | d_error, read mismatch or response timeout; err_idx_o names the op
module tlul_boot_seq
  import tlul_pkg::*;
  import tlul_boot_seq_pkg::*;
#(
  parameter int                     NumOps     = 4,
  parameter seq_op_t [NumOps-1:0]   SeqTable   = '0,
  parameter int                     StartDelay = 1500,
  parameter int                     RspTimeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  err_idx_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o
);

  localparam logic [DelayW-1:0] DelayLast   = DelayW'(StartDelay);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(RspTimeout - 1);
  localparam logic [IdxW-1:0]   LastIdx     = IdxW'(NumOps - 1);

  boot_state_e       state_q, state_d;
  logic [DelayW-1:0] delay_q, delay_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  seq_op_t           cur_op;

  always_comb begin
    cur_op = '0;
    for (int i = 0; i < NumOps; i++) begin
      if (idx_q == IdxW'(i)) cur_op = SeqTable[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      delay_q       <= '0;
      timer_q       <= '0;
      idx_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    delay_d       = delay_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    tl_o          = TL_H2D_DEFAULT;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StDelay;
          delay_d = '0;
          idx_d   = '0;
        end
      end

      StDelay: begin
        if (delay_q == DelayLast) begin
          state_d = StReq;
          timer_d = '0;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end

      StReq: begin
        tl_o.a_valid   = 1'b1;
        tl_o.a_opcode  = (cur_op.kind == SeqRead) ? Get : PutFullData;
        tl_o.a_address = cur_op.addr;
        tl_o.a_data    = cur_op.data;
        tl_o.a_size    = 2'd2;
        tl_o.a_mask    = 4'hF;
        tl_o.a_source  = 8'h00;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        timer_d        = '0;
        if (tl_i.a_ready) state_d = StRsp;
      end

      // A response landing on the acceptance edge is not seen here: only RSP looks at d_valid.
      StRsp: begin
        timer_d = timer_q + 1'b1;
        if (tl_i.d_valid) begin
          if (cur_op.kind == SeqRead) begin
            rdata_d       = tl_i.d_data;
            rdata_valid_d = 1'b1;
          end
          if (tl_i.d_error) begin
            state_d = StError;
          end else if (cur_op.kind == SeqRead && !read_matches(cur_op, tl_i.d_data)) begin
            state_d = StError;
          end else if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            timer_d = '0;
            state_d = StReq;
          end
        end else if (timer_q == TimeoutLast) begin
          state_d = StError;
        end
      end

      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  assign busy_o        = (state_q == StDelay) || (state_q == StReq) || (state_q == StRsp);
  assign done_o        = (state_q == StDone);
  assign err_o         = (state_q == StError);
  assign err_idx_o     = err_o ? idx_q : '0;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                       tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_boot_seq.sv
// Directed bench for tlul_boot_seq: long start delay on one instance, op table
// behaviour (reads, errors, stalls, timeout, reset) on a short-delay instance.
module tb_tlul_boot_seq;
  import tlul_pkg::*;
  import tlul_boot_seq_pkg::*;

  localparam logic [31:0] KEYMGR_CONTROL_SHADOWED = 32'h4114_0014;

  localparam seq_op_t OP_A  = '{kind: SeqWrite, addr: KEYMGR_CONTROL_SHADOWED,
                                data: 32'h0000_0012, cmp_mask: 32'h0};
  localparam seq_op_t OP_B0 = '{kind: SeqRead,  addr: 32'h0000_0100,
                                data: 32'h0000_00A5, cmp_mask: 32'h0000_00FF};
  localparam seq_op_t OP_B1 = '{kind: SeqWrite, addr: 32'h0000_0104,
                                data: 32'hDEAD_BEEF, cmp_mask: 32'h0};
  localparam seq_op_t OP_B2 = '{kind: SeqWrite, addr: 32'h0000_0108,
                                data: 32'h0000_0005, cmp_mask: 32'h0};

  localparam seq_op_t [0:0] TBL_A = {OP_A};
  localparam seq_op_t [2:0] TBL_B = {OP_B2, OP_B1, OP_B0};

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  tl_h2d_t     tl_a_req, tl_b_req;
  tl_d2h_t     tl_a_rsp, tl_b_rsp;
  logic        busy_a, done_a, err_a, rdata_valid_a;
  logic        busy_b, done_b, err_b, rdata_valid_b;
  logic [3:0]  err_idx_a, err_idx_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  tlul_boot_seq #(
    .NumOps(1), .SeqTable(TBL_A), .StartDelay(1500), .RspTimeout(255)
  ) dut_a (
    .clk_i(clk_sys), .rst_i(rst), .start_i(start_a),
    .tl_o(tl_a_req), .tl_i(tl_a_rsp),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_idx_o(err_idx_a),
    .rdata_o(rdata_a), .rdata_valid_o(rdata_valid_a)
  );

  tlul_boot_seq #(
    .NumOps(3), .SeqTable(TBL_B), .StartDelay(2), .RspTimeout(8)
  ) dut_b (
    .clk_i(clk_sys), .rst_i(rst), .start_i(start_b),
    .tl_o(tl_b_req), .tl_i(tl_b_rsp),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_idx_o(err_idx_b),
    .rdata_o(rdata_b), .rdata_valid_o(rdata_valid_b)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_b = 1'b0;
    tl_b_rsp = TL_D2H_DEFAULT;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_b(input logic [31:0] data, input logic derr);
    tl_b_rsp.d_valid = 1'b1;
    tl_b_rsp.d_data  = data;
    tl_b_rsp.d_error = derr;
    step();
    tl_b_rsp.d_valid = 1'b0;
    tl_b_rsp.d_error = 1'b0;
  endtask

  task automatic start_seq_b();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
  endtask

  task automatic wait_a_b(output int n);
    n = 0;
    while (tl_b_req.a_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (tl_b_req !== TL_H2D_DEFAULT) begin errors++; $display("FAIL reset_tl got %h exp %h", tl_b_req, TL_H2D_DEFAULT); end
    checks++; if ({busy_a, done_a, err_a, rdata_valid_a} !== 4'b0) begin errors++; $display("FAIL reset_flags_a got %b exp 0000", {busy_a, done_a, err_a, rdata_valid_a}); end
    checks++; if ({busy_b, done_b, err_b, rdata_valid_b} !== 4'b0) begin errors++; $display("FAIL reset_flags_b got %b exp 0000", {busy_b, done_b, err_b, rdata_valid_b}); end
    checks++; if (err_idx_b !== 4'h0 || rdata_b !== 32'h0) begin errors++; $display("FAIL reset_data got idx %h rdata %h exp 0 0", err_idx_b, rdata_b); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (busy_b !== 1'b0 || tl_b_req.a_valid !== 1'b0) begin errors++; $display("FAIL idle_no_start got busy %b a_valid %b exp 0 0", busy_b, tl_b_req.a_valid); end
  endtask

  task automatic test_start_delay();
    int n;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL delay_busy got %b exp 1", busy_a); end
    n = 0;
    while (tl_a_req.a_valid !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    checks++; if (n !== 1501) begin errors++; $display("FAIL delay_first_a got %0d exp 1501", n); end
    checks++; if (tl_a_req.a_opcode !== PutFullData || tl_a_req.a_address !== KEYMGR_CONTROL_SHADOWED || tl_a_req.a_data !== 32'h12) begin
      errors++; $display("FAIL delay_a_fields got op %h addr %h data %h exp 0 %h 12", tl_a_req.a_opcode, tl_a_req.a_address, tl_a_req.a_data, KEYMGR_CONTROL_SHADOWED);
    end
    checks++; if (tl_a_req.a_size !== 2'd2 || tl_a_req.a_mask !== 4'hF || tl_a_req.a_source !== 8'h0) begin
      errors++; $display("FAIL delay_a_shape got size %h mask %h src %h exp 2 f 0", tl_a_req.a_size, tl_a_req.a_mask, tl_a_req.a_source);
    end
    step();
    checks++; if (tl_a_req.a_valid !== 1'b0) begin errors++; $display("FAIL delay_a_drop got %b exp 0", tl_a_req.a_valid); end
    step();
    tl_a_rsp.d_valid = 1'b1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL delay_done_early got %b exp 0", done_a); end
    step();
    tl_a_rsp.d_valid = 1'b0;
    checks++; if (done_a !== 1'b1 || err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL delay_done got done %b err %b busy %b exp 1 0 0", done_a, err_a, busy_a);
    end
  endtask

  task automatic test_read_ok();
    int n;
    do_reset();
    start_seq_b();
    wait_a_b(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL read_first_a got %0d exp 3", n); end
    checks++; if (tl_b_req.a_opcode !== Get || tl_b_req.a_address !== 32'h100 || tl_b_req.a_user !== TL_A_USER_DEFAULT) begin
      errors++; $display("FAIL read_a_fields got op %h addr %h user %h exp 4 100 %h", tl_b_req.a_opcode, tl_b_req.a_address, tl_b_req.a_user, TL_A_USER_DEFAULT);
    end
    step();
    send_b(32'h1234_56A5, 1'b0);
    checks++; if (rdata_valid_b !== 1'b1 || rdata_b !== 32'h1234_56A5) begin
      errors++; $display("FAIL read_rdata got vld %b data %h exp 1 123456a5", rdata_valid_b, rdata_b);
    end
    checks++; if (tl_b_req.a_valid !== 1'b1 || tl_b_req.a_address !== 32'h104 || tl_b_req.a_opcode !== PutFullData || tl_b_req.a_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_next_op got vld %b addr %h op %h data %h exp 1 104 0 deadbeef", tl_b_req.a_valid, tl_b_req.a_address, tl_b_req.a_opcode, tl_b_req.a_data);
    end
    step();
    checks++; if (rdata_valid_b !== 1'b0) begin errors++; $display("FAIL read_pulse_width got %b exp 0", rdata_valid_b); end
    send_b(32'h0, 1'b0);
    checks++; if (tl_b_req.a_address !== 32'h108 || rdata_valid_b !== 1'b0) begin
      errors++; $display("FAIL read_third_op got addr %h vld %b exp 108 0", tl_b_req.a_address, rdata_valid_b);
    end
    step();
    send_b(32'h0, 1'b0);
    checks++; if (done_b !== 1'b1 || err_b !== 1'b0 || busy_b !== 1'b0 || tl_b_req !== TL_H2D_DEFAULT) begin
      errors++; $display("FAIL read_done got done %b err %b busy %b tl %h", done_b, err_b, busy_b, tl_b_req);
    end
    start_b = 1'b1;
    step();
    step();
    start_b = 1'b0;
    checks++; if (done_b !== 1'b1 || tl_b_req.a_valid !== 1'b0) begin
      errors++; $display("FAIL done_sticky got done %b a_valid %b exp 1 0", done_b, tl_b_req.a_valid);
    end
  endtask

  task automatic test_d_error();
    int n;
    int seen;
    do_reset();
    start_seq_b();
    wait_a_b(n);
    step();
    send_b(32'h0000_00A5, 1'b0);
    step();
    send_b(32'h0, 1'b1);
    checks++; if (err_b !== 1'b1 || err_idx_b !== 4'd1 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      errors++; $display("FAIL derr_state got err %b idx %0d busy %b done %b exp 1 1 0 0", err_b, err_idx_b, busy_b, done_b);
    end
    checks++; if (tl_b_req !== TL_H2D_DEFAULT) begin errors++; $display("FAIL derr_tl got %h exp %h", tl_b_req, TL_H2D_DEFAULT); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tl_b_req.a_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0 || err_b !== 1'b1 || err_idx_b !== 4'd1) begin
      errors++; $display("FAIL derr_no_third got a_valid cycles %0d err %b idx %0d exp 0 1 1", seen, err_b, err_idx_b);
    end
  endtask

  task automatic test_read_mismatch();
    int n;
    do_reset();
    start_seq_b();
    wait_a_b(n);
    step();
    send_b(32'hFFFF_00A4, 1'b0);
    checks++; if (err_b !== 1'b1 || err_idx_b !== 4'd0) begin errors++; $display("FAIL mismatch_err got err %b idx %0d exp 1 0", err_b, err_idx_b); end
    checks++; if (rdata_valid_b !== 1'b1 || rdata_b !== 32'hFFFF_00A4) begin
      errors++; $display("FAIL mismatch_rdata got vld %b data %h exp 1 ffff00a4", rdata_valid_b, rdata_b);
    end
  endtask

  task automatic test_stall_timeout();
    int n;
    int stall_bad;
    int seen;
    do_reset();
    tl_b_rsp.a_ready = 1'b0;
    start_seq_b();
    tl_b_rsp.d_valid = 1'b1;
    tl_b_rsp.d_error = 1'b1;
    checks++; if (tl_b_req.d_ready !== 1'b1) begin errors++; $display("FAIL stray_d_ready got %b exp 1", tl_b_req.d_ready); end
    step();
    tl_b_rsp.d_valid = 1'b0;
    tl_b_rsp.d_error = 1'b0;
    checks++; if (err_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL stray_d_ignored got err %b busy %b exp 0 1", err_b, busy_b); end
    wait_a_b(n);
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tl_b_req.a_valid !== 1'b1 || tl_b_req.a_address !== 32'h100 || tl_b_req.a_opcode !== Get || tl_b_req.a_data !== 32'hA5 || tl_b_req.a_mask !== 4'hF)
        stall_bad++;
      step();
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stall_bad); end
    tl_b_rsp.a_ready = 1'b1;
    tl_b_rsp.d_valid = 1'b1;
    tl_b_rsp.d_error = 1'b1;
    step();
    tl_b_rsp.d_valid = 1'b0;
    tl_b_rsp.d_error = 1'b0;
    checks++; if (tl_b_req.a_valid !== 1'b0 || err_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++; $display("FAIL accept_same_cycle_d got a_valid %b err %b busy %b exp 0 0 1", tl_b_req.a_valid, err_b, busy_b);
    end
    seen = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      if (tl_b_req.a_valid === 1'b1) seen++;
    end
    checks++; if (err_b !== 1'b0) begin errors++; $display("FAIL timeout_early got err %b at 7 cycles exp 0", err_b); end
    step();
    checks++; if (err_b !== 1'b1 || err_idx_b !== 4'd0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL timeout_err got err %b idx %0d busy %b exp 1 0 0", err_b, err_idx_b, busy_b);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL stall_dup_req got %0d extra request cycles exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    do_reset();
    start_seq_b();
    wait_a_b(n);
    step();
    send_b(32'h1234_56A5, 1'b0);
    step();
    checks++; if (busy_b !== 1'b1 || rdata_b !== 32'h1234_56A5) begin
      errors++; $display("FAIL rstmid_pre got busy %b rdata %h exp 1 123456a5", busy_b, rdata_b);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({busy_b, done_b, err_b, rdata_valid_b} !== 4'b0 || rdata_b !== 32'h0 || err_idx_b !== 4'h0) begin
      errors++; $display("FAIL rstmid_outputs got flags %b rdata %h idx %h exp 0000 0 0", {busy_b, done_b, err_b, rdata_valid_b}, rdata_b, err_idx_b);
    end
    checks++; if (tl_b_req !== TL_H2D_DEFAULT) begin errors++; $display("FAIL rstmid_tl got %h exp %h", tl_b_req, TL_H2D_DEFAULT); end
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tl_b_req.a_valid === 1'b1 || busy_b === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_reissue got %0d active cycles exp 0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    start_a  = 1'b0;
    start_b  = 1'b0;
    tl_a_rsp = TL_D2H_DEFAULT;
    tl_b_rsp = TL_D2H_DEFAULT;
    test_reset();
    test_start_delay();
    test_read_ok();
    test_d_error();
    test_read_mismatch();
    test_stall_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_boot_seq.md
TLUL_BOOT_SEQ -- requirements
Module: tlul_boot_seq

Interface
REQ-001 Parameter NumOps, default 4, number of entries in SeqTable (1..16).
REQ-002 Parameter SeqTable, default all-zero seq_op_t array, ordered op list (kind, address, data, compare mask).
REQ-003 Parameter StartDelay, default 1500, cycles from start acceptance to first A request (0..4095).
REQ-004 Parameter RspTimeout, default 255, max cycles waiting for D response (1..255).
REQ-005 Single clock domain; reset asynchronous, active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 start_i  in  1  level; sampled in IDLE to launch the sequence.
REQ-009 tl_o  out  tl_h2d_t  TL-UL host request channel toward the RoT crossbar.
REQ-010 tl_i  in  tl_d2h_t  TL-UL device response channel.
REQ-011 busy_o  out  1  high from start acceptance until DONE or ERROR.
REQ-012 done_o  out  1  sticky; all ops completed without error.
REQ-013 err_o  out  1  sticky; d_error, read mismatch, or timeout.
REQ-014 err_idx_o  out  4  index of the failing op.
REQ-015 rdata_o  out  32  last read response data; rdata_valid_o  out  1  one-cycle pulse per read response.

Function
REQ-016 States: IDLE, DELAY, REQ, RSP, DONE, ERROR.
REQ-017 IDLE: start_i=1 -> DELAY, delay counter cleared, op index 0, busy_o=1.
REQ-018 DELAY: count up each cycle; at count == StartDelay -> REQ; StartDelay=0 -> REQ on next cycle.
REQ-019 REQ: a_valid=1, a_opcode PutFullData (0x0) for write kind, Get (0x4) for read kind, a_address/a_data from table, a_size=2, a_mask=4'hF, a_source=0, a_user=TL_A_USER_DEFAULT, d_ready=1.
REQ-020 A fields held stable while a_valid=1 and a_ready=0; on a_valid&&a_ready -> RSP next cycle with a_valid=0.
REQ-021 RSP: d_ready=1; timeout counter increments each cycle; on d_valid: d_error=1 -> ERROR; read kind with (d_data & mask) != (data & mask) -> ERROR; otherwise advance.
REQ-022 Advance: index == NumOps-1 -> DONE, else index+1 -> REQ next cycle (no idle gap beyond one cycle).
REQ-023 Timeout counter reaching RspTimeout without d_valid -> ERROR; counter cleared on each REQ entry.
REQ-024 d_valid arriving in the same cycle as A acceptance is not consumed; responses observed only in RSP.
REQ-025 rdata_o updated and rdata_valid_o pulsed on every read-kind d_valid in RSP, including mismatching reads.
REQ-026 ERROR: err_o=1, err_idx_o=current index, busy_o=0, tl_o=TL_H2D_DEFAULT with d_ready=1; remain until reset.
REQ-027 DONE: done_o=1, busy_o=0, tl_o=TL_H2D_DEFAULT; remain until reset; start_i ignored.
REQ-028 start_i ignored outside IDLE.
REQ-029 d_valid with no outstanding request (any state but RSP) ignored and accepted (d_ready=1).

Reset
REQ-030 rst_i asserted: state IDLE, tl_o=TL_H2D_DEFAULT, busy_o=done_o=err_o=rdata_valid_o=0, err_idx_o=0, rdata_o=0, counters 0, immediately (asynchronous).
REQ-031 Reset mid-transaction abandons the op; no request reissued until a new start_i after deassertion.

Structure
REQ-032 Package tlul_boot_seq_pkg holds seq_kind_e (SeqWrite, SeqRead), seq_op_t {kind, addr[31:0], data[31:0], cmp_mask[31:0]}, and state enum.
REQ-033 Single flat module; no sub-module; TL types taken from tlul_pkg.

Verification
REQ-034 StartDelay=1500, one write 0x12 to KEYMGR_CONTROL_SHADOWED, a_ready=1, response after 2 cycles -> a_valid first seen 1501 cycles after start, done_o=1 three cycles later, err_o=0.
REQ-035 Read op expecting 0xA5 mask 0xFF, device returns 0x1234_56A5 -> rdata_o=0x123456A5, rdata_valid_o pulse, done_o=1.
REQ-036 Second of three ops returns d_error=1 -> err_o=1, err_idx_o=1, third op never issued.
REQ-037 a_ready held 0 for 10 cycles -> A fields stable throughout, single handshake, no duplicate request.
REQ-038 RspTimeout=8, device never responds -> err_o=1 exactly 8 cycles after A acceptance, err_idx_o=0.
REQ-039 rst_i asserted during RSP -> all outputs reset values same cycle; no further A traffic without new start_i.
